// File: rtl/stream_pkg.sv
// Shared definitions for the slice-streaming serializer and unpacker.
//   nbeats_f(width, slice) : number of beats needed to carry a width-bit word
//   rem_f(width, slice)    : bits carried by the final beat (1..slice)
//   stream_hs_t            : valid/ready/last handshake bundle of a slice link
package stream_pkg;

    function automatic int unsigned nbeats_f(input int unsigned width,
                                             input int unsigned slice);
        return (width + slice - 1) / slice;
    endfunction

    function automatic int unsigned rem_f(input int unsigned width,
                                          input int unsigned slice);
        return width - (nbeats_f(width, slice) - 1) * slice;
    endfunction

    typedef struct packed {
        logic valid;
        logic ready;
        logic last;
    } stream_hs_t;

endpackage

// File: rtl/stream_slice_reorder.sv
// Combinational left-stream reorder: reordered = {<< SLICE {word}}.
// Slices are taken from word starting at the LSB and placed into reordered
// starting at the MSB; a partial top slice of word lands at the result LSBs.
// Ports:
//   word      : input word
//   reordered : slice-reversed word
module stream_slice_reorder
    import stream_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] reordered
);

    localparam int unsigned NBEATS = nbeats_f(WIDTH, SLICE);
    localparam int unsigned REM    = rem_f(WIDTH, SLICE);

    // Full slices: LSB slice j of the input becomes MSB slice j of the result.
    for (genvar j = 0; j < int'(NBEATS) - 1; j++) begin : g_full
        assign reordered[WIDTH-1-j*SLICE -: SLICE] = word[j*SLICE +: SLICE];
    end

    // The remaining (possibly partial) top slice of the input fills the LSBs.
    assign reordered[REM-1:0] = word[WIDTH-1 -: REM];

endmodule

// File: rtl/stream_slice_unpacker.sv
// Slice-serial receiver: collects SLICE-bit beats into a WIDTH-bit word,
// optionally applies the {<< SLICE {}} reorder, and holds the result in a
// single-entry valid/ready output register.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   s_valid/s_ready : input beat handshake
//   s_data, s_last  : beat payload and end-of-word marker
//   m_valid/m_ready : output word handshake
//   m_data          : reassembled word
//   err             : one-cycle pulse on a framing error
module stream_slice_unpacker
    import stream_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4,
    parameter bit          LEFT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [SLICE-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             err
);

    localparam int unsigned NBEATS = nbeats_f(WIDTH, SLICE);
    localparam int unsigned REM    = rem_f(WIDTH, SLICE);
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    // Accumulator only needs the bits of the non-final beats.
    localparam int unsigned ACC_W  = (NBEATS > 1) ? (NBEATS - 1) * SLICE : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             err_q, err_d;

    logic [ACC_W-1:0] acc_shift;
    logic [WIDTH-1:0] word_plain;
    logic [WIDTH-1:0] word_out;
    logic             at_last;
    logic             accept;
    stream_hs_t       s_hs;

    assign at_last = (cnt_q == LAST_CNT);

    // Only the final beat can stall, and only while the output cannot drain.
    assign s_hs.valid = s_valid;
    assign s_hs.ready = !at_last || !m_valid_q || m_ready;
    assign s_hs.last  = s_last;
    assign accept     = s_hs.valid && s_hs.ready;

    // Word assembly; beat 0 ends up at the MSB of the plain word.
    if (NBEATS == 1) begin : g_single
        assign acc_shift  = '0;
        assign word_plain = s_data[REM-1:0];
    end else if (NBEATS == 2) begin : g_two
        assign acc_shift  = s_data;
        assign word_plain = {acc_q, s_data[REM-1:0]};
    end else begin : g_multi
        assign acc_shift  = {acc_q[ACC_W-SLICE-1:0], s_data};
        assign word_plain = {acc_q, s_data[REM-1:0]};
    end

    if (LEFT) begin : g_left
        stream_slice_reorder #(
            .WIDTH (WIDTH),
            .SLICE (SLICE)
        ) u_reorder (
            .word      (word_plain),
            .reordered (word_out)
        );
    end else begin : g_right
        assign word_out = word_plain;
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        m_valid_d = m_valid_q && !m_ready;
        m_data_d  = m_data_q;
        err_d     = 1'b0;

        if (accept) begin
            if (at_last) begin
                // Word completes regardless of s_last; a missing marker is flagged.
                m_data_d  = word_out;
                m_valid_d = 1'b1;
                cnt_d     = '0;
                acc_d     = '0;
                err_d     = !s_hs.last;
            end else if (s_hs.last) begin
                // Early end-of-word: drop the partial word.
                cnt_d = '0;
                acc_d = '0;
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = acc_shift;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            err_q     <= err_d;
        end
    end

    assign s_ready = s_hs.ready;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign err     = err_q;

endmodule

// File: tb/tb_stream_slice_unpacker.sv
// Bench for stream_slice_unpacker: four configurations side by side
//   0: WIDTH=4  SLICE=1 LEFT=1      1: WIDTH=32 SLICE=3 LEFT=1
//   2: WIDTH=11 SLICE=4 LEFT=1      3: WIDTH=32 SLICE=8 LEFT=0
// Expected words come from the SV streaming operator and go into per-instance
// queues when a word is driven; the monitor pops them on each output handshake.
module tb_stream_slice_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid [4];
    logic        s_ready [4];
    logic [7:0]  s_data  [4];
    logic        s_last  [4];
    logic        m_valid [4];
    logic        m_ready [4];
    logic [31:0] m_data  [4];
    logic        err     [4];

    logic [3:0]  md0;
    logic [31:0] md1;
    logic [10:0] md2;
    logic [31:0] md3;

    logic [31:0] exp_q [4][$];
    int          errors = 0;
    int          checks = 0;
    int          err_cnt [4];
    int          last_wait;
    int          rst_events = 0;

    always #5 clk = ~clk;

    stream_slice_unpacker #(.WIDTH(4), .SLICE(1), .LEFT(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_data(s_data[0][0:0]), .s_last(s_last[0]), .m_valid(m_valid[0]),
        .m_ready(m_ready[0]), .m_data(md0), .err(err[0]));
    stream_slice_unpacker #(.WIDTH(32), .SLICE(3), .LEFT(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_data(s_data[1][2:0]), .s_last(s_last[1]), .m_valid(m_valid[1]),
        .m_ready(m_ready[1]), .m_data(md1), .err(err[1]));
    stream_slice_unpacker #(.WIDTH(11), .SLICE(4), .LEFT(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
        .s_data(s_data[2][3:0]), .s_last(s_last[2]), .m_valid(m_valid[2]),
        .m_ready(m_ready[2]), .m_data(md2), .err(err[2]));
    stream_slice_unpacker #(.WIDTH(32), .SLICE(8), .LEFT(1'b0)) u_dut3 (
        .clk(clk), .rst(rst), .s_valid(s_valid[3]), .s_ready(s_ready[3]),
        .s_data(s_data[3]), .s_last(s_last[3]), .m_valid(m_valid[3]),
        .m_ready(m_ready[3]), .m_data(md3), .err(err[3]));

    assign m_data[0] = {28'b0, md0};
    assign m_data[1] = md1;
    assign m_data[2] = {21'b0, md2};
    assign m_data[3] = md3;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int width_of(input int i);
        case (i)
            0: return 4;
            1: return 32;
            2: return 11;
            default: return 32;
        endcase
    endfunction

    function automatic int slice_of(input int i);
        case (i)
            0: return 1;
            1: return 3;
            2: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [31:0] model(input int i, input logic [31:0] c);
        logic [3:0]  c4, r4;
        logic [10:0] c11, r11;
        logic [31:0] r32;
        case (i)
            0: begin c4 = c[3:0]; r4 = {<< 1 {c4}}; return {28'b0, r4}; end
            1: begin r32 = {<< 3 {c}}; return r32; end
            2: begin c11 = c[10:0]; r11 = {<< 4 {c11}}; return {21'b0, r11}; end
            default: return c;
        endcase
    endfunction

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic send_beat(input int i, input logic [7:0] d, input logic last,
                             input bit final_beat);
        int n = 0;
        s_valid[i] = 1'b1;
        s_data[i]  = d;
        s_last[i]  = last;
        @(negedge clk);
        while (!s_ready[i] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("ready_timeout", 32'(n), 32'(0));
        if (!final_beat) check("nonfinal_stall", 32'(n), 32'(0));
        last_wait = n;
        @(posedge clk);
        #1;
        s_valid[i] = 1'b0;
        s_last[i]  = 1'b0;
    endtask

    task automatic send_word(input int i, input logic [31:0] c, input bit push,
                             input bit mark_last);
        int w = width_of(i);
        int s = slice_of(i);
        int n = (w + s - 1) / s;
        int r = w - (n - 1) * s;
        logic [31:0] beat;
        if (push) exp_q[i].push_back(model(i, c));
        for (int k = 0; k < n; k++) begin
            if (k < n - 1) beat = (c >> (w - (k + 1) * s)) & ((32'h1 << s) - 32'h1);
            else           beat = c & ((32'h1 << r) - 32'h1);
            send_beat(i, beat[7:0], (k == n - 1) && mark_last, k == n - 1);
        end
    endtask

    // Scoreboard pop, output-hold stability and err pulse-width monitor.
    logic        hold_prev [4];
    logic [31:0] data_prev [4];
    logic        err_prev  [4];
    int          rst_seen  = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i] && m_ready[i]) begin
                if (exp_q[i].size() == 0) check("sb_nonempty", 32'(0), 32'(1));
                else check("word", m_data[i], exp_q[i].pop_front());
            end
            if (hold_prev[i] && rst_seen == rst_events) check("hold", m_data[i], data_prev[i]);
            if (err_prev[i]) check("err_width", 32'(err[i]), 32'(0));
            if (err[i]) err_cnt[i]++;
            hold_prev[i] = m_valid[i] && !m_ready[i];
            data_prev[i] = m_data[i];
            err_prev[i]  = err[i];
        end
        rst_seen = rst_events;
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            s_valid[i] = 1'b0; s_data[i] = 8'h0; s_last[i] = 1'b0; m_ready[i] = 1'b1;
            err_cnt[i] = 0; hold_prev[i] = 1'b0; data_prev[i] = 32'h0; err_prev[i] = 1'b0;
        end
        rst = 1'b1;
        #2;
        for (int i = 0; i < 4; i++) begin
            check("rst_m_valid", 32'(m_valid[i]), 32'(0));
            check("rst_m_data", m_data[i], 32'h0);
            check("rst_err", 32'(err[i]), 32'(0));
            check("rst_s_ready", 32'(s_ready[i]), 32'(1));
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Config 0: beats 0,0,0,1 -> 4'b1000.
        send_word(0, 32'h1, 1'b1, 1'b1);
        check("a_valid", 32'(m_valid[0]), 32'(1));
        check("a_data", m_data[0], 32'h8);
        check("a_err", 32'(err[0]), 32'(0));
        @(posedge clk); #1;
        check("a_valid_drop", 32'(m_valid[0]), 32'(0));
        send_word(0, 32'h6, 1'b1, 1'b1);

        // Config 1: 32-bit word in 3-bit slices with a 2-bit final beat.
        send_word(1, 32'hD70A4497, 1'b1, 1'b1);
        check("b_data", m_data[1], 32'he92910eb);
        for (int t = 0; t < 3; t++) send_word(1, $urandom(), 1'b1, 1'b1);

        // Config 2: 11-bit word, final beat of 3 bits.
        send_word(2, 32'h497, 1'b1, 1'b1);
        check("c_data", m_data[2], 32'h3cc);
        for (int t = 0; t < 3; t++) send_word(2, $urandom() & 32'h7ff, 1'b1, 1'b1);
        // Final beat without s_last: word still emitted, err pulses.
        send_word(2, 32'h5a3, 1'b1, 1'b0);
        check("c_nolast_err", 32'(err[2]), 32'(1));
        check("c_nolast_valid", 32'(m_valid[2]), 32'(1));

        // Config 3: back-to-back words with output back-pressure.
        m_ready[3] = 1'b0;
        send_word(3, 32'h04030201, 1'b1, 1'b1);
        check("d_first", m_data[3], 32'h04030201);
        fork
            send_word(3, 32'h08070605, 1'b1, 1'b1);
            begin
                repeat (5) @(posedge clk);
                #1 m_ready[3] = 1'b1;
            end
        join
        check("d_final_stall", 32'(last_wait > 0), 32'(1));
        check("d_second", m_data[3], 32'h08070605);

        // Early s_last on beat 2: err pulse, nothing emitted, then a clean word.
        @(posedge clk); #1;
        send_beat(3, 8'h55, 1'b0, 1'b0);
        send_beat(3, 8'h66, 1'b1, 1'b0);
        check("e_err", 32'(err[3]), 32'(1));
        check("e_no_valid", 32'(m_valid[3]), 32'(0));
        @(posedge clk); #1;
        check("e_err_clear", 32'(err[3]), 32'(0));
        send_word(3, 32'h11223344, 1'b1, 1'b1);
        check("e_word", m_data[3], 32'h11223344);

        // Reset with a pending output and a half-collected word.
        @(posedge clk); #1;
        m_ready[3] = 1'b0;
        send_word(3, 32'hdeadbeef, 1'b0, 1'b1);
        send_beat(3, 8'hab, 1'b0, 1'b0);
        send_beat(3, 8'hcd, 1'b0, 1'b0);
        #2 rst = 1'b1;
        rst_events++;
        #1;
        check("f_rst_valid", 32'(m_valid[3]), 32'(0));
        check("f_rst_data", m_data[3], 32'h0);
        check("f_rst_err", 32'(err[3]), 32'(0));
        check("f_rst_ready", 32'(s_ready[3]), 32'(1));
        #1 rst = 1'b0;
        m_ready[3] = 1'b1;
        @(posedge clk); #1;
        send_word(3, 32'hcafe0123, 1'b1, 1'b1);
        check("f_word", m_data[3], 32'hcafe0123);
        check("f_err", 32'(err[3]), 32'(0));

        // Drain and close out the scoreboard.
        for (int n = 0; n < 20; n++) begin
            if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() == 0)
                break;
            @(posedge clk);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) check("sb_drained", 32'(exp_q[i].size()), 32'(0));
        check("err_cnt0", 32'(err_cnt[0]), 32'(0));
        check("err_cnt1", 32'(err_cnt[1]), 32'(0));
        check("err_cnt2", 32'(err_cnt[2]), 32'(1));
        check("err_cnt3", 32'(err_cnt[3]), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
